// File: rtl/sram_arb_pkg.sv
// Shared types and default constants for the SRAM access arbiter.
// Imported by the arbiter top and its pin driver.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } arb_grant_e;

    localparam int          DEF_WAIT_CYCLES = 5;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
    localparam int          DEF_SRAM_AW     = 17;

    // Byte offset from the SRAM window base; wraps modulo 2^32 below the base.
    function automatic logic [31:0] byteOffset(input logic [31:0] addr,
                                               input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/sram_pin_driver.sv
// SRAM pin timing: DQ tristate, write-enable pulse shaping and read-data capture
// into the per-port read registers.
module sram_pin_driver
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  arb_state_e  state_i,
    input  arb_grant_e  grant_i,
    input  logic [3:0]  cnt_i,
    input  logic        wr_i,
    input  logic [31:0] wdata_i,
    inout  wire  [63:0] sram_dq_io,
    output logic        sram_we_n_o,
    output logic [31:0] if_rdata_o,
    output logic [31:0] mem_rdata_o
);

    logic        drive;
    logic        lastCycle;
    logic [31:0] if_rdata_q;
    logic [31:0] mem_rdata_q;
    logic        unusedUpperLanes;

    assign lastCycle = (cnt_i == 4'(WAIT_CYCLES - 1));
    assign drive     = (state_i == ACCESS) && wr_i;

    // Data stays driven through the final ACCESS cycle while WE_N has already risen.
    assign sram_dq_io  = drive ? {32'h0, wdata_i} : 64'bz;
    assign sram_we_n_o = ~(drive && !lastCycle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else if ((state_i == ACCESS) && !wr_i && lastCycle) begin
            if (grant_i == DATA) begin
                mem_rdata_q <= sram_dq_io[31:0];
            end else if (grant_i == INSTR) begin
                if_rdata_q <= sram_dq_io[31:0];
            end
        end
    end

    assign if_rdata_o       = if_rdata_q;
    assign mem_rdata_o      = mem_rdata_q;
    assign unusedUpperLanes = ^sram_dq_io[63:32];

endmodule

// File: rtl/sram_access_arbiter.sv
// Two-port SRAM arbiter: data port beats instruction fetch, each request becomes
// a fixed-length SRAM cycle followed by a one-cycle ready pulse.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          SRAM_AW     = DEF_SRAM_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic [31:0]        if_rdata,
    output logic               if_ready,
    input  logic               mem_rd,
    input  logic               mem_wr,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    output logic [31:0]        mem_rdata,
    output logic               mem_ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [63:0]        SRAM_DQ,
    output logic               SRAM_WE_N
);

    arb_state_e         state_q, state_d;
    arb_grant_e         grant_q, grant_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic               wr_q, wr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic [31:0] ifOffset;
    logic [31:0] memOffset;
    logic        memReq;
    logic        unusedOffsetBits;

    assign ifOffset  = byteOffset(if_addr, BASE_ADDR);
    assign memOffset = byteOffset(mem_addr, BASE_ADDR);
    assign memReq    = mem_rd | mem_wr;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (memReq) begin
                    grant_d = DATA;
                    addr_d  = memOffset[SRAM_AW+1:2];
                    wr_d    = mem_wr;
                    wdata_d = mem_wdata;
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end else if (if_req) begin
                    grant_d = INSTR;
                    addr_d  = ifOffset[SRAM_AW+1:2];
                    wr_d    = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = NONE;
            end
            default: begin
                state_d = IDLE;
                grant_d = NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= NONE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    // An idle port reports ready so it never freezes the pipeline.
    assign mem_ready = ~memReq | ((state_q == DONE) && (grant_q == DATA));
    assign if_ready  = ~if_req | ((state_q == DONE) && (grant_q == INSTR));
    assign SRAM_ADDR = (state_q == IDLE) ? '0 : addr_q;

    sram_pin_driver #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_pins (
        .clk        (clk),
        .rst_n      (reset),
        .state_i    (state_q),
        .grant_i    (grant_q),
        .cnt_i      (cnt_q),
        .wr_i       (wr_q),
        .wdata_i    (wdata_q),
        .sram_dq_io (SRAM_DQ),
        .sram_we_n_o(SRAM_WE_N),
        .if_rdata_o (if_rdata),
        .mem_rdata_o(mem_rdata)
    );

    assign unusedOffsetBits = ^{ifOffset[31:SRAM_AW+2], ifOffset[1:0],
                                memOffset[31:SRAM_AW+2], memOffset[1:0]};

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for the SRAM arbiter: directed transaction table, hand-written corner
// sequences and randomized traffic, all checked against a transaction-level model.
module tb_sram_access_arbiter;

    localparam int          W    = 5;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [16:0] sramAddr;
    wire  [63:0] sramDq;
    logic        sramWeN;

    logic        tbDrive;
    logic [63:0] tbData;
    assign sramDq = tbDrive ? tbData : 64'bz;

    sram_access_arbiter #(
        .WAIT_CYCLES(W),
        .BASE_ADDR  (BASE),
        .SRAM_AW    (17)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .SRAM_ADDR(sramAddr),
        .SRAM_DQ  (sramDq),
        .SRAM_WE_N(sramWeN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level model state: one outstanding access, accepted at cycle tAcc.
    int          cyc = 0;
    bit          busy = 0;
    int          tAcc = 0;
    int          gnt = 0;
    bit          isWr = 0;
    logic [16:0] addrW = '0;
    logic [31:0] wdat = '0;
    logic [31:0] expIf = '0;
    logic [31:0] expMem = '0;
    bit          doneIf = 0;
    bit          doneMem = 0;
    bit          lastIfReady = 0;
    bit          lastMemReady = 0;
    logic [16:0] busAddrSeen = '0;

    logic [63:0] sram [logic [16:0]];

    typedef struct {
        bit          isMem;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [16:0] expAddr;
        logic [31:0] expData;
    } vec_t;

    vec_t table_v[9];

    function automatic logic [63:0] memRead(input logic [16:0] a);
        if (sram.exists(a)) return sram[a];
        return {15'h0, a, 32'h1357_0000 + {15'h0, a}};
    endfunction

    function automatic logic [16:0] wordOf(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[18:2];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: called at a negedge with inputs already applied.
    task automatic applyStimulus();
        int          p;
        bit          inAccess;
        bit          inDone;
        logic [63:0] rdWord;
        p        = busy ? (cyc - tAcc) : 0;
        inAccess = busy && (p >= 1) && (p <= W);
        inDone   = busy && (p == W + 1);
        tbDrive  = !(inAccess && isWr);
        tbData   = (inAccess && !isWr) ? memRead(sramAddr) : 64'h0;
        #1;
        checkOutput("sram_addr", {47'h0, sramAddr}, (inAccess || inDone) ? {47'h0, addrW} : 64'h0);
        checkOutput("we_n", {63'h0, sramWeN}, {63'h0, !(inAccess && isWr && (p <= W - 1))});
        checkOutput("dq", sramDq, (inAccess && isWr) ? {32'h0, wdat} : tbData);
        checkOutput("mem_ready", {63'h0, mem_ready},
                    {63'h0, !(mem_rd || mem_wr) || (inDone && gnt == 2)});
        checkOutput("if_ready", {63'h0, if_ready}, {63'h0, !if_req || (inDone && gnt == 1)});
        checkOutput("if_rdata", {32'h0, if_rdata}, {32'h0, expIf});
        checkOutput("mem_rdata", {32'h0, mem_rdata}, {32'h0, expMem});
        lastIfReady  = if_ready;
        lastMemReady = mem_ready;
        if (inAccess) busAddrSeen = sramAddr;
        doneIf  = 0;
        doneMem = 0;
        if (!sramWeN) sram[sramAddr] = sramDq;
        if (inAccess && !isWr && p == W) begin
            rdWord = memRead(addrW);
            if (gnt == 2) expMem = rdWord[31:0];
            else          expIf  = rdWord[31:0];
        end
        if (inDone) begin
            busy    = 0;
            doneMem = (gnt == 2);
            doneIf  = (gnt == 1);
        end else if (!busy) begin
            if (mem_rd || mem_wr) begin
                busy = 1; tAcc = cyc; gnt = 2; isWr = mem_wr;
                addrW = wordOf(mem_addr); wdat = mem_wdata;
            end else if (if_req) begin
                busy = 1; tAcc = cyc; gnt = 1; isWr = 0;
                addrW = wordOf(if_addr);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && busy; i++) applyStimulus();
        checkOutput("drain_timeout", {63'h0, busy}, 64'h0);
    endtask

    task automatic runTxn(input vec_t v);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        if (v.isMem) begin
            mem_rd = v.rd; mem_wr = v.wr; mem_addr = v.addr; mem_wdata = v.wdata;
        end else begin
            if_req = 1; if_addr = v.addr;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            applyStimulus();
            n++;
            seen = v.isMem ? lastMemReady : lastIfReady;
        end
        checkOutput("txn_latency", n, W + 2);
        checkOutput("txn_addr", {47'h0, busAddrSeen}, {47'h0, v.expAddr});
        mem_rd = 0; mem_wr = 0; if_req = 0;
        checkOutput("txn_rdata", {32'h0, v.isMem ? mem_rdata : if_rdata}, {32'h0, v.expData});
    endtask

    initial begin
        int firstMem, firstIf, pulses, p1, p2, n;
        bit holdIf, holdMem;
        table_v[0] = '{1, 0, 1, 32'd1028, 32'hDEAD_BEEF, 17'h00001, 32'h0000_0000};
        table_v[1] = '{1, 1, 0, 32'd1028, 32'h0,         17'h00001, 32'hDEAD_BEEF};
        table_v[2] = '{1, 1, 0, 32'd1020, 32'h0,         17'h1FFFF, 32'h1234_5678};
        table_v[3] = '{0, 1, 0, 32'd1031, 32'h0,         17'h00001, 32'hDEAD_BEEF};
        table_v[4] = '{1, 1, 1, 32'd1036, 32'h0BAD_F00D, 17'h00003, 32'h1234_5678};
        table_v[5] = '{0, 1, 0, 32'd1036, 32'h0,         17'h00003, 32'h0BAD_F00D};
        table_v[6] = '{1, 1, 0, 32'd1039, 32'h0,         17'h00003, 32'h0BAD_F00D};
        table_v[7] = '{1, 0, 1, 32'd0,    32'h55AA_55AA, 17'h1FF00, 32'h0BAD_F00D};
        table_v[8] = '{0, 1, 0, 32'd0,    32'h0,         17'h1FF00, 32'h55AA_55AA};
        sram[17'h1FFFF] = 64'hFFFF_FFFF_1234_5678;

        reset = 0; if_req = 0; if_addr = 0; mem_rd = 0; mem_wr = 0;
        mem_addr = 0; mem_wdata = 0; tbDrive = 1; tbData = 64'h0;
        @(negedge clk);
        #1;
        checkOutput("rst_if_ready", {63'h0, if_ready}, 64'h1);
        checkOutput("rst_mem_ready", {63'h0, mem_ready}, 64'h1);
        checkOutput("rst_we_n", {63'h0, sramWeN}, 64'h1);
        checkOutput("rst_addr", {47'h0, sramAddr}, 64'h0);
        checkOutput("rst_dq", sramDq, 64'h0);
        checkOutput("rst_rdata", {if_rdata, mem_rdata}, 64'h0);
        @(negedge clk);
        reset = 1;

        foreach (table_v[i]) runTxn(table_v[i]);

        // Simultaneous requests: data first, fetch waits out the whole data access.
        if_req = 1; if_addr = 32'd1028; mem_rd = 1; mem_addr = 32'd1036;
        firstMem = -1; firstIf = -1;
        for (int i = 0; i < 30 && firstIf < 0; i++) begin
            applyStimulus();
            if (lastIfReady) firstIf = i;
            if (lastMemReady && mem_rd && firstMem < 0) begin
                firstMem = i;
                mem_rd = 0;
            end
        end
        checkOutput("prio_mem_ready_at", firstMem, W + 1);
        checkOutput("prio_if_ready_at", firstIf, 2 * W + 3);
        if_req = 0; mem_rd = 0;
        drain();

        // Held read: back-to-back accesses, one ready pulse each.
        mem_rd = 1; mem_addr = 32'd1028;
        pulses = 0; p1 = -1; p2 = -1;
        for (int i = 0; i < 2 * W + 4; i++) begin
            applyStimulus();
            if (lastMemReady) begin
                pulses++;
                if (p1 < 0) p1 = i; else p2 = i;
            end
        end
        checkOutput("b2b_pulses", pulses, 2);
        checkOutput("b2b_first", p1, W + 1);
        checkOutput("b2b_second", p2, 2 * W + 3);
        mem_rd = 0;
        drain();

        // Reset during the third ACCESS cycle of a write aborts at once.
        mem_wr = 1; mem_addr = 32'd1044; mem_wdata = 32'h1357_9BDF;
        for (int i = 0; i < 3; i++) applyStimulus();
        tbDrive = 1; tbData = 64'h0;
        reset = 0;
        #1;
        checkOutput("abort_we_n", {63'h0, sramWeN}, 64'h1);
        checkOutput("abort_dq", sramDq, 64'h0);
        checkOutput("abort_addr", {47'h0, sramAddr}, 64'h0);
        checkOutput("abort_mem_ready", {63'h0, mem_ready}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("abort_hold_ready", {63'h0, mem_ready}, 64'h0);
        checkOutput("abort_rdata", {if_rdata, mem_rdata}, 64'h0);
        @(negedge clk);
        busy = 0; expIf = 0; expMem = 0;
        reset = 1;
        n = 0;
        lastMemReady = 0;
        for (int i = 0; i < 40 && !lastMemReady; i++) begin
            applyStimulus();
            n++;
        end
        checkOutput("abort_restart_latency", n, W + 2);
        mem_wr = 0;
        drain();

        // Randomized traffic on both ports; requests held until their own ready.
        holdIf = 0; holdMem = 0;
        for (int i = 0; i < 400; i++) begin
            if (holdMem && doneMem) begin
                holdMem = 0; mem_rd = 0; mem_wr = 0;
            end
            if (holdIf && doneIf) begin
                holdIf = 0; if_req = 0;
            end
            if (!holdMem && ($urandom % 3 == 0)) begin
                int kind;
                kind = $urandom % 3;
                holdMem = 1;
                mem_rd = (kind != 1);
                mem_wr = (kind != 0);
                mem_addr = BASE + ($urandom_range(0, 7) << 2) + ($urandom % 4)
                           - (($urandom % 8 == 0) ? 32'd16 : 32'd0);
                mem_wdata = $urandom;
            end
            if (!holdIf && ($urandom % 3 == 0)) begin
                holdIf = 1;
                if_req = 1;
                if_addr = BASE + ($urandom_range(0, 7) << 2) + ($urandom % 4)
                          - (($urandom % 8 == 0) ? 32'd16 : 32'd0);
            end
            applyStimulus();
        end
        mem_rd = 0; mem_wr = 0; if_req = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
